// File: rtl/hazard_ctrl_unit.sv
// Hazard control for the 5-stage RV32 pipeline: EX operand forwarding, load-use,
// MUL/DIV and data-memory-wait stalls. Optional perf counters under HAZ_PERF_CNT_EN.
module hazard_ctrl_unit #(
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_BUBBLES = 1,
  parameter int MULDIV_LAT   = 4,
  parameter int CNT_W        = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic [1:0]            ResultSrcE,
  input  logic                  PCSrcE,
  input  logic                  MulDivStE,
  input  logic                  MemReqM,
  input  logic                  MemReadyM,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushM,
  output logic                  FlushW,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_events
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LD_WAIT,
    S_MD_BUSY
  } state_t;

  localparam logic [CNT_W-1:0] LD_INIT = CNT_W'(LOAD_BUBBLES - 1);
  localparam logic [CNT_W-1:0] MD_INIT = CNT_W'(MULDIV_LAT - 2);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_mem_stall;
  logic             w_load_use;
  logic             w_pc_flush;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rd_m,
    input logic                  we_m,
    input logic [REG_ADDR_W-1:0] rd_w,
    input logic                  we_w
  );
    if (we_m && (rd_m != '0) && (rd_m == rs))      return 2'b10;
    else if (we_w && (rd_w != '0) && (rd_w == rs)) return 2'b01;
    else                                           return 2'b00;
  endfunction

  always_comb begin
    w_mem_stall = MemReqM && !MemReadyM;
    w_load_use  = (ResultSrcE == 2'b01) && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pc_flush  = 1'b0;
    StallF      = 1'b0;
    StallD      = 1'b0;
    StallE      = 1'b0;
    StallM      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    FlushM      = 1'b0;
    FlushW      = 1'b0;
    ForwardAE   = 2'b00;
    ForwardBE   = 2'b00;

    if (rst) begin
      FlushD      = 1'b1;
      FlushE      = 1'b1;
      FlushM      = 1'b1;
      FlushW      = 1'b1;
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

      if (w_mem_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (PCSrcE) begin
              FlushD     = 1'b1;
              FlushE     = 1'b1;
              w_pc_flush = 1'b1;
            end else if (w_load_use) begin
              StallF = 1'b1;
              StallD = 1'b1;
              FlushE = 1'b1;
              if (LOAD_BUBBLES > 1) begin
                w_state_nxt = S_LD_WAIT;
                w_cnt_nxt   = LD_INIT;
              end
            end else if (MulDivStE && (MULDIV_LAT > 1)) begin
              StallF = 1'b1;
              StallD = 1'b1;
              StallE = 1'b1;
              FlushM = 1'b1;
              // cnt holds the busy cycles still owed after this one, so the
              // whole sequence stalls MULDIV_LAT-1 cycles.
              if (MULDIV_LAT > 2) begin
                w_state_nxt = S_MD_BUSY;
                w_cnt_nxt   = MD_INIT;
              end
            end
          end
          S_LD_WAIT: begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
            if (r_cnt <= CNT_W'(1)) begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt - CNT_W'(1);
            end
          end
          S_MD_BUSY: begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
            if (r_cnt <= CNT_W'(1)) begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt - CNT_W'(1);
            end
          end
          default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (StallF && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
      if (w_pc_flush && (flush_events != '1)) flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit (LOAD_BUBBLES=2, MULDIV_LAT=4):
// directed scenarios plus randomized traffic against a remaining-stall-cycles model.
module tb_hazard_ctrl_unit;

  localparam int LB  = 2;
  localparam int LAT = 4;

  // Observed vector layout: {StallF,StallD,StallE,StallM, FlushD,FlushE,FlushM,FlushW, FwdA, FwdB}
  localparam logic [11:0] IDLE_V = 12'b0000_0000_0000;
  localparam logic [11:0] RST_V  = 12'b0000_1111_0000;
  localparam logic [11:0] LD_V   = 12'b1100_0100_0000;
  localparam logic [11:0] MD_V   = 12'b1110_0010_0000;
  localparam logic [11:0] BR_V   = 12'b0000_1100_0000;
  localparam logic [11:0] MEM_V  = 12'b1111_0001_0000;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, PCSrcE, MulDivStE, MemReqM, MemReadyM;
  logic [1:0] ResultSrcE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  logic [11:0] w_obs;
  assign w_obs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, ForwardAE, ForwardBE};

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(
    .REG_ADDR_W  (5),
    .LOAD_BUBBLES(LB),
    .MULDIV_LAT  (LAT),
    .CNT_W       (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Rs1D      (Rs1D),
    .Rs2D      (Rs2D),
    .Rs1E      (Rs1E),
    .Rs2E      (Rs2E),
    .RdE       (RdE),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .ResultSrcE(ResultSrcE),
    .PCSrcE    (PCSrcE),
    .MulDivStE (MulDivStE),
    .MemReqM   (MemReqM),
    .MemReadyM (MemReadyM),
    .StallF    (StallF),
    .StallD    (StallD),
    .StallE    (StallE),
    .StallM    (StallM),
    .FlushD    (FlushD),
    .FlushE    (FlushE),
    .FlushM    (FlushM),
    .FlushW    (FlushW),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_events(flush_events)
`endif
  );

  // Reference model: number of stall cycles still owed by the current event and its kind.
  int m_left = 0;
  bit m_is_load = 1'b0;

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs)      return 2'b10;
    else if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit ref_load_use();
    return (ResultSrcE == 2'b01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
  endfunction

  function automatic logic [11:0] model_exp();
    logic [11:0] v;
    if (rst) return RST_V;
    if (MemReqM && !MemReadyM)      v = MEM_V;
    else if (m_left > 0)            v = m_is_load ? LD_V : MD_V;
    else if (PCSrcE)                v = BR_V;
    else if (ref_load_use())        v = LD_V;
    else if (MulDivStE && LAT > 1)  v = MD_V;
    else                            v = IDLE_V;
    v[3:0] = {ref_fwd(Rs1E), ref_fwd(Rs2E)};
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0;
    end else if (MemReqM && !MemReadyM) begin
      m_left <= m_left;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
    end else if (PCSrcE) begin
      m_left <= 0;
    end else if (ref_load_use()) begin
      m_left    <= LB - 1;
      m_is_load <= 1'b1;
    end else if (MulDivStE && LAT > 1) begin
      m_left    <= LAT - 2;
      m_is_load <= 1'b0;
    end
  end

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0;
    MulDivStE = 0; MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic test_reset();
    logic [11:0] exp_v [0:8];
    exp_v = '{RST_V, IDLE_V, MD_V, MD_V, RST_V, RST_V, IDLE_V, MD_V, MD_V};
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      clear_inputs();
      rst       = (c == 0 || c == 4 || c == 5);
      MulDivStE = (c == 2 || c == 7);
      #1;
      n_vec++;
      if (w_obs !== exp_v[c]) begin
        n_err++;
        $display("FAIL reset_c%0d: got %b expected %b", c, w_obs, exp_v[c]);
      end
    end
    // restarted sequence must still run its full length from a cleared counter
    @(negedge clk); clear_inputs(); #1;
    n_vec++;
    if (w_obs !== MD_V) begin
      n_err++;
      $display("FAIL reset_restart_tail: got %b expected %b", w_obs, MD_V);
    end
    @(negedge clk); #1;
    n_vec++;
    if (w_obs !== IDLE_V) begin
      n_err++;
      $display("FAIL reset_restart_end: got %b expected %b", w_obs, IDLE_V);
    end
  endtask

  task automatic test_forwarding();
    logic [4:0] t_rs1 [0:4];
    logic [4:0] t_rs2 [0:4];
    logic [4:0] t_rdm [0:4];
    logic [4:0] t_rdw [0:4];
    logic       t_wem [0:4];
    logic       t_wew [0:4];
    logic [3:0] t_exp [0:4];
    t_rs1 = '{5'd5, 5'd5, 5'd0, 5'd3, 5'd9};
    t_rs2 = '{5'd6, 5'd5, 5'd3, 5'd9, 5'd9};
    t_rdm = '{5'd5, 5'd0, 5'd0, 5'd3, 5'd9};
    t_rdw = '{5'd5, 5'd5, 5'd0, 5'd9, 5'd9};
    t_wem = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    t_wew = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    t_exp = '{4'b1000, 4'b0101, 4'b0000, 4'b0001, 4'b1010};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      clear_inputs();
      Rs1E = t_rs1[k]; Rs2E = t_rs2[k]; RdM = t_rdm[k]; RdW = t_rdw[k];
      RegWriteM = t_wem[k]; RegWriteW = t_wew[k];
      #1;
      n_vec++;
      if (w_obs !== {8'b0, t_exp[k]}) begin
        n_err++;
        $display("FAIL fwd_case%0d: got %b expected %b", k, w_obs, {8'b0, t_exp[k]});
      end
    end
  endtask

  task automatic test_load_use();
    logic [11:0] exp_v [0:7];
    exp_v = '{LD_V, LD_V, IDLE_V, BR_V, IDLE_V, IDLE_V, LD_V, LD_V};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      clear_inputs();
      case (c)
        0: begin ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; end
        3: begin ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; PCSrcE = 1; end
        5: begin ResultSrcE = 2'b01; RdE = 0; Rs1D = 0; Rs2D = 0; end
        6: begin ResultSrcE = 2'b01; RdE = 3; Rs1D = 3; end
        default: ;
      endcase
      #1;
      n_vec++;
      if (w_obs !== exp_v[c]) begin
        n_err++;
        $display("FAIL load_use_c%0d: got %b expected %b", c, w_obs, exp_v[c]);
      end
    end
    @(negedge clk); clear_inputs(); #1;
    n_vec++;
    if (w_obs !== IDLE_V) begin
      n_err++;
      $display("FAIL load_use_end: got %b expected %b", w_obs, IDLE_V);
    end
  endtask

  task automatic test_muldiv();
    logic [11:0] exp_v [0:4];
    exp_v = '{MD_V, MD_V, MD_V, IDLE_V, IDLE_V};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      clear_inputs();
      MulDivStE = (c == 0 || c == 1);
      #1;
      n_vec++;
      if (w_obs !== exp_v[c]) begin
        n_err++;
        $display("FAIL muldiv_c%0d: got %b expected %b", c, w_obs, exp_v[c]);
      end
    end
  endtask

  task automatic test_memstall();
    logic [11:0] exp_v [0:9];
    exp_v = '{MD_V, MD_V, MEM_V, MEM_V, MEM_V, MD_V, IDLE_V, MEM_V, IDLE_V, BR_V};
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      clear_inputs();
      case (c)
        0: MulDivStE = 1;
        2, 3, 4: MemReqM = 1;
        5: begin MemReqM = 1; MemReadyM = 1; end
        7: begin MemReqM = 1; PCSrcE = 1; end
        9: PCSrcE = 1;
        default: ;
      endcase
      #1;
      n_vec++;
      if (w_obs !== exp_v[c]) begin
        n_err++;
        $display("FAIL memstall_c%0d: got %b expected %b", c, w_obs, exp_v[c]);
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] e;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 49) == 0);
      Rs1D       = 5'($urandom_range(0, 3));
      Rs2D       = 5'($urandom_range(0, 3));
      Rs1E       = 5'($urandom_range(0, 3));
      Rs2E       = 5'($urandom_range(0, 3));
      RdE        = 5'($urandom_range(0, 3));
      RdM        = 5'($urandom_range(0, 3));
      RdW        = 5'($urandom_range(0, 3));
      RegWriteM  = 1'($urandom_range(0, 1));
      RegWriteW  = 1'($urandom_range(0, 1));
      ResultSrcE = 2'($urandom_range(0, 3));
      PCSrcE     = ($urandom_range(0, 5) == 0);
      MulDivStE  = ($urandom_range(0, 7) == 0);
      MemReqM    = ($urandom_range(0, 3) == 0);
      MemReadyM  = 1'($urandom_range(0, 1));
      #1;
      e = model_exp();
      n_vec++;
      if (w_obs !== e) begin
        n_err++;
        $display("FAIL random_c%0d: got %b expected %b", c, w_obs, e);
      end
    end
  endtask

`ifdef HAZ_PERF_CNT_EN
  task automatic test_perf();
    @(negedge clk); clear_inputs(); rst = 1;
    @(negedge clk); rst = 0; #1;
    n_vec++;
    if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
      n_err++;
      $display("FAIL perf_reset: got %0d/%0d expected 0/0", stall_cycles, flush_events);
    end
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    @(negedge clk); clear_inputs();
    @(negedge clk); PCSrcE = 1;
    @(negedge clk); clear_inputs();
    @(negedge clk); #1;
    n_vec++;
    if (stall_cycles !== 32'd2 || flush_events !== 32'd1) begin
      n_err++;
      $display("FAIL perf_counts: got %0d/%0d expected 2/1", stall_cycles, flush_events);
    end
  endtask
`endif

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_muldiv();
    test_memstall();
    test_random();
`ifdef HAZ_PERF_CNT_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
